// File: rtl/parity_pkg.sv
// Shared parity definitions: FSM state type, parity convention and helper.
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        REPORT = 2'd2
    } state_e;

    // Parity bit value for an even count of 1s (codebase-wide convention).
    localparam logic PAR_EVEN = 1'b1;

    localparam int unsigned PAR_VEC_W = 32;

    function automatic logic par_even(input logic [PAR_VEC_W-1:0] vec);
        return (^vec) ? ~PAR_EVEN : PAR_EVEN;
    endfunction

endpackage

// File: rtl/parity_frame_checker_if.sv
// Beat stream and result handshake between the deframer and the frame checker.
interface parity_frame_checker_if #(
    parameter int unsigned DATA_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_par;
    logic              abort;
    logic              res_valid;
    logic              res_ready;
    logic              res_par;
    logic              res_err;

    modport master (
        output in_valid, in_data, in_par, abort, res_ready,
        input  in_ready, res_valid, res_par, res_err
    );

    modport slave (
        input  in_valid, in_data, in_par, abort, res_ready,
        output in_ready, res_valid, res_par, res_err
    );
endinterface

// File: rtl/parity_reduce.sv
// Shared parity datapath: 1 when the beat holds an odd number of 1s.
module parity_reduce #(
    parameter int unsigned DATA_W = 4
) (
    input  logic [DATA_W-1:0] in_data_i,
    output logic              p_beat_o
);
    assign p_beat_o = ^in_data_i;
endmodule

// File: rtl/parity_frame_checker.sv
// Frame sequencer: folds FRAME_LEN beats into a parity, reports pass/fail, counts errors.
module parity_frame_checker
    import parity_pkg::*;
#(
    parameter int unsigned DATA_W    = 4,
    parameter int unsigned FRAME_LEN = 8,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    parity_frame_checker_if.slave bus,
    input  logic                 clr_cnt,
    output logic [CNT_W-1:0]     err_cnt
);
    localparam int unsigned       BEAT_W    = $clog2(FRAME_LEN + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    state_e             state_q, state_d;
    logic               acc_q, acc_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic               res_par_q, res_par_d;
    logic               res_err_q, res_err_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic               p_beat;
    logic               frame_par;
    logic               beat_accept;

    parity_reduce #(.DATA_W(DATA_W)) u_reduce (
        .in_data_i (bus.in_data),
        .p_beat_o  (p_beat)
    );

    assign frame_par     = par_even(PAR_VEC_W'({acc_q, p_beat}));
    assign bus.in_ready  = (state_q != REPORT);
    assign bus.res_valid = (state_q == REPORT);
    assign bus.res_par   = res_par_q;
    assign bus.res_err   = res_err_q;
    assign err_cnt       = err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= 1'b0;
            beat_q    <= '0;
            res_par_q <= 1'b0;
            res_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            beat_q    <= beat_d;
            res_par_q <= res_par_d;
            res_err_q <= res_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // abort overrides beats and handshakes; clr_cnt overrides any increment
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        beat_d      = beat_q;
        res_par_d   = res_par_q;
        res_err_d   = res_err_q;
        err_cnt_d   = err_cnt_q;
        beat_accept = bus.in_valid && (state_q != REPORT);

        if (bus.abort) begin
            state_d = IDLE;
            acc_d   = 1'b0;
            beat_d  = '0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (beat_accept) begin
                        if (beat_q == LAST_BEAT) begin
                            res_par_d = frame_par;
                            res_err_d = (frame_par != bus.in_par);
                            acc_d     = 1'b0;
                            beat_d    = '0;
                            state_d   = REPORT;
                        end else begin
                            acc_d   = acc_q ^ p_beat;
                            beat_d  = beat_q + BEAT_W'(1);
                            state_d = ACCUM;
                        end
                    end
                end
                REPORT: begin
                    if (bus.res_ready) begin
                        state_d = IDLE;
                        if (res_err_q && (err_cnt_q != CNT_MAX)) begin
                            err_cnt_d = err_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (clr_cnt) begin
            err_cnt_d = '0;
        end
    end

endmodule

// File: tb/tb_parity_frame_checker.sv
// Randomized self-checking bench for parity_frame_checker against a ones-count frame model.
module tb_parity_frame_checker;
    import parity_pkg::*;

    localparam int unsigned DATA_W    = 4;
    localparam int unsigned FRAME_LEN = 4;
    localparam int unsigned CNT_W     = 8;
    localparam int          CNT_SAT   = (1 << CNT_W) - 1;

    typedef logic [DATA_W-1:0] frame_t [FRAME_LEN];

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clr_cnt;
    logic [CNT_W-1:0] err_cnt;

    int total   = 0;
    int bad     = 0;
    int exp_cnt = 0;

    parity_frame_checker_if #(.DATA_W(DATA_W)) bus ();

    parity_frame_checker #(
        .DATA_W    (DATA_W),
        .FRAME_LEN (FRAME_LEN),
        .CNT_W     (CNT_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .clr_cnt (clr_cnt),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Frame parity from the total ones count of the whole frame.
    function automatic logic model_par(input frame_t f);
        int ones = 0;
        foreach (f[i]) ones += $countones(f[i]);
        return (ones % 2 == 0) ? PAR_EVEN : ~PAR_EVEN;
    endfunction

    task automatic send_frame(input frame_t f, input logic par, input bit gaps,
                              input string name, output logic ep, output logic ee);
        ep = model_par(f);
        ee = (ep != par);
        for (int i = 0; i < int'(FRAME_LEN); i++) begin
            if (gaps) begin
                int idle;
                idle = $urandom_range(0, 2);
                repeat (idle) begin
                    bus.in_valid = 1'b0;
                    bus.in_data  = DATA_W'($urandom);
                    step();
                    total++;
                    if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                        bad++;
                        $display("FAIL %s gap: res_valid=%b in_ready=%b want 0 1", name, bus.res_valid, bus.in_ready);
                    end
                end
            end
            total++;
            if (bus.in_ready !== 1'b1) begin
                bad++;
                $display("FAIL %s ready beat %0d: got %b want 1", name, i, bus.in_ready);
            end
            bus.in_valid = 1'b1;
            bus.in_data  = f[i];
            bus.in_par   = (i == int'(FRAME_LEN) - 1) ? par : 1'($urandom);
            step();
            if (i != int'(FRAME_LEN) - 1) begin
                total++;
                if (bus.res_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL %s early res_valid after beat %0d: got %b want 0", name, i, bus.res_valid);
                end
            end
        end
        bus.in_valid = 1'b0;
        total++;
        if (bus.res_valid !== 1'b1 || bus.res_par !== ep || bus.res_err !== ee || bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL %s result: valid=%b par=%b err=%b ready=%b want 1 %b %b 0",
                     name, bus.res_valid, bus.res_par, bus.res_err, bus.in_ready, ep, ee);
        end
    endtask

    task automatic handshake(input logic ee, input logic clr, input string name);
        bus.res_ready = 1'b1;
        clr_cnt       = clr;
        step();
        bus.res_ready = 1'b0;
        clr_cnt       = 1'b0;
        if (clr) exp_cnt = 0;
        else if (ee && exp_cnt < CNT_SAT) exp_cnt++;
        total++;
        if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1 || err_cnt !== CNT_W'(exp_cnt)) begin
            bad++;
            $display("FAIL %s handshake: valid=%b ready=%b err_cnt=%0d want 0 1 %0d",
                     name, bus.res_valid, bus.in_ready, err_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #23;
        total++;
        if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.res_par !== 1'b0 ||
            bus.res_err !== 1'b0 || err_cnt !== '0) begin
            bad++;
            $display("FAIL reset: valid=%b ready=%b par=%b err=%b cnt=%0d want 0 1 0 0 0",
                     bus.res_valid, bus.in_ready, bus.res_par, bus.res_err, err_cnt);
        end
        rst_n = 1'b1;
        exp_cnt = 0;
        step();
    endtask

    task automatic test_basic();
        frame_t f;
        logic ep, ee;
        f = '{4'h3, 4'h5, 4'h0, 4'hF};
        send_frame(f, 1'b1, 1'b0, "pass_frame", ep, ee);
        handshake(ee, 1'b0, "pass_frame");
        f = '{4'h1, 4'h0, 4'h0, 4'h0};
        send_frame(f, 1'b1, 1'b0, "fail_frame", ep, ee);
        handshake(ee, 1'b0, "fail_frame");
    endtask

    task automatic test_backpressure();
        frame_t f;
        logic ep, ee, ep2, ee2;
        foreach (f[i]) f[i] = DATA_W'($urandom);
        send_frame(f, 1'($urandom), 1'b0, "bp_frame", ep, ee);
        bus.in_valid = 1'b1;
        bus.in_data  = 4'h1;
        repeat (5) begin
            step();
            total++;
            if (bus.in_ready !== 1'b0 || bus.res_valid !== 1'b1 || bus.res_par !== ep || bus.res_err !== ee) begin
                bad++;
                $display("FAIL bp_hold: ready=%b valid=%b par=%b err=%b want 0 1 %b %b",
                         bus.in_ready, bus.res_valid, bus.res_par, bus.res_err, ep, ee);
            end
        end
        handshake(ee, 1'b0, "bp_frame");
        foreach (f[i]) f[i] = DATA_W'($urandom);
        send_frame(f, 1'($urandom), 1'b0, "bp_next", ep2, ee2);
        handshake(ee2, 1'b0, "bp_next");
    endtask

    task automatic test_abort();
        frame_t f;
        logic ep, ee;
        repeat (2) begin
            bus.in_valid = 1'b1;
            bus.in_data  = DATA_W'($urandom);
            step();
        end
        bus.abort    = 1'b1;
        bus.in_data  = 4'hF;
        step();
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        total++;
        if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL abort_mid: valid=%b ready=%b want 0 1", bus.res_valid, bus.in_ready);
        end
        f = '{4'h7, 4'h0, 4'h0, 4'h0};
        send_frame(f, 1'b0, 1'b0, "abort_new", ep, ee);
        handshake(ee, 1'b0, "abort_new");
        f = '{4'h1, 4'h0, 4'h0, 4'h0};
        send_frame(f, 1'b1, 1'b0, "abort_rep", ep, ee);
        bus.abort     = 1'b1;
        bus.res_ready = 1'b1;
        step();
        bus.abort     = 1'b0;
        bus.res_ready = 1'b0;
        total++;
        if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1 || err_cnt !== CNT_W'(exp_cnt)) begin
            bad++;
            $display("FAIL abort_report: valid=%b ready=%b cnt=%0d want 0 1 %0d",
                     bus.res_valid, bus.in_ready, err_cnt, exp_cnt);
        end
    endtask

    task automatic test_random();
        frame_t f;
        logic ep, ee;
        int wait_n;
        for (int n = 0; n < 40; n++) begin
            foreach (f[i]) f[i] = DATA_W'($urandom);
            send_frame(f, 1'($urandom), 1'b1, "rand", ep, ee);
            wait_n = $urandom_range(0, 3);
            repeat (wait_n) begin
                bus.in_valid = 1'($urandom);
                bus.in_data  = DATA_W'($urandom);
                step();
                total++;
                if (bus.res_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.res_par !== ep || bus.res_err !== ee) begin
                    bad++;
                    $display("FAIL rand_hold: valid=%b ready=%b par=%b err=%b want 1 0 %b %b",
                             bus.res_valid, bus.in_ready, bus.res_par, bus.res_err, ep, ee);
                end
            end
            bus.in_valid = 1'b0;
            handshake(ee, ($urandom_range(0, 7) == 0), "rand");
        end
    endtask

    task automatic test_saturate();
        frame_t f;
        logic ep, ee;
        f = '{4'h1, 4'h0, 4'h0, 4'h0};
        for (int n = 0; n < 256; n++) begin
            send_frame(f, 1'b1, 1'b0, "sat", ep, ee);
            handshake(ee, 1'b0, "sat");
        end
        total++;
        if (err_cnt !== 8'hFF) begin
            bad++;
            $display("FAIL sat_level: got %0d want 255", err_cnt);
        end
        send_frame(f, 1'b1, 1'b0, "sat_hold", ep, ee);
        handshake(ee, 1'b0, "sat_hold");
        send_frame(f, 1'b1, 1'b0, "sat_clr", ep, ee);
        handshake(ee, 1'b1, "sat_clr");
    endtask

    task automatic test_async_reset();
        frame_t f;
        logic ep, ee;
        f = '{4'h1, 4'h0, 4'h0, 4'h0};
        send_frame(f, 1'b1, 1'b0, "ar_pre", ep, ee);
        handshake(ee, 1'b0, "ar_pre");
        repeat (2) begin
            bus.in_valid = 1'b1;
            bus.in_data  = DATA_W'($urandom);
            step();
        end
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.res_par !== 1'b0 ||
            bus.res_err !== 1'b0 || err_cnt !== '0) begin
            bad++;
            $display("FAIL async_reset: valid=%b ready=%b par=%b err=%b cnt=%0d want 0 1 0 0 0",
                     bus.res_valid, bus.in_ready, bus.res_par, bus.res_err, err_cnt);
        end
        #1;
        rst_n   = 1'b1;
        exp_cnt = 0;
        step();
        f = '{4'h3, 4'h5, 4'h0, 4'hF};
        send_frame(f, 1'b1, 1'b0, "ar_fresh", ep, ee);
        handshake(ee, 1'b0, "ar_fresh");
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_par    = 1'b0;
        bus.abort     = 1'b0;
        bus.res_ready = 1'b0;
        clr_cnt       = 1'b0;
        rst_n         = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_abort();
        test_random();
        test_saturate();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
